// File: rtl/dmem_access_unit.sv
// Data-memory access stage: takes one read/write request from the control unit,
// waits WAIT_CYCLES clocks, then accesses an internal word-addressed RAM.
module dmem_access_unit #(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic              rd_req,
   input  logic              wr_req,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              addr_err,
   output logic [1:0]        state_dbg
);

   localparam int         RAM_DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [3:0] WAIT_LD   = 4'(WAIT_CYCLES);

   if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
      $error("dmem_access_unit: WAIT_CYCLES must be in 1..15");
   end
   if (DEPTH_LOG2 > ADDR_W) begin : g_bad_depth
      $error("dmem_access_unit: DEPTH_LOG2 must not exceed ADDR_W");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic [3:0]              cnt;
   logic [ADDR_W-1:0]       lat_addr;
   logic [DATA_W-1:0]       lat_data;
   logic                    lat_wr;
   logic                    err_flag;
   logic                    req;
   logic                    access_now;
   logic                    out_of_range;
   logic [DEPTH_LOG2-1:0]   ram_idx;
   logic [DATA_W-1:0]       ram [0:RAM_DEPTH-1];

   // Handshake: a request level is sampled only in IDLE; busy stays high from the
   // accepting edge until the DONE cycle ends, and done is a one-cycle pulse.
   assign req          = rd_req | wr_req;
   assign access_now   = (state == S_ACCESS) && (cnt == 4'd1);
   assign out_of_range = (lat_addr >> DEPTH_LOG2) != '0;
   assign ram_idx      = lat_addr[DEPTH_LOG2-1:0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (req) state_nxt = S_ACCESS;
         S_ACCESS: if (cnt == 4'd1) state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state == S_ACCESS) || (state == S_DONE);
      done      = (state == S_DONE);
      addr_err  = (state == S_DONE) && err_flag;
      state_dbg = state;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt       <= '0;
         lat_addr  <= '0;
         lat_data  <= '0;
         lat_wr    <= 1'b0;
         err_flag  <= 1'b0;
         mem_rdata <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req) begin
                  lat_addr <= mem_addr;
                  lat_data <= mem_wdata;
                  lat_wr   <= wr_req;   // write wins; a simultaneous read is dropped
                  cnt      <= WAIT_LD;
               end
            end
            S_ACCESS: begin
               if (cnt != 4'd1) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  err_flag <= out_of_range;
                  if (!lat_wr) mem_rdata <= out_of_range ? '0 : ram[ram_idx];
               end
            end
            S_DONE:  err_flag <= 1'b0;
            default: err_flag <= 1'b0;
         endcase
      end
   end

   // RAM contents survive reset; a reset before the access edge leaves state IDLE.
   always_ff @(posedge clock) begin
      if (access_now && lat_wr && !out_of_range) ram[ram_idx] <= lat_data;
   end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Data-memory stage directly downstream of the memory data register (MDDR) and the memory address register (MAR).
- Accepts one read or write request from the control unit and performs a multi-cycle access to an internal word-addressed RAM.
- Write data comes from the MDDR data-side output. Read data goes back to the MDDR data input.
- A busy/done handshake lets the control FSM stall until the access completes.

Parameters:
- DATA_W, 16, data word width (matches A_bus).
- ADDR_W, 16, width of the incoming MAR address.
- DEPTH_LOG2, 8, log2 of the RAM depth (256 words); legal addresses are 0 .. 2**DEPTH_LOG2-1.
- WAIT_CYCLES, 2, access latency in clocks; legal range 1..15.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_addr  in  ADDR_W  word address from MAR.
- mem_wdata  in  DATA_W  write data from the MDDR data-side output.
- rd_req  in  1  read request level from the control unit.
- wr_req  in  1  write request level from the control unit.
- mem_rdata  out  DATA_W  registered read data, driving the MDDR data input.
- busy  out  1  high while an accepted access is in progress (ACCESS or DONE).
- done  out  1  one-cycle completion pulse.
- addr_err  out  1  high together with done when the completed access was out of range.

Behaviour:
- One clock domain. Reset is asynchronous and active-high, on ports clock and reset.
- Reset values:
  - State = IDLE, counter = 0.
  - mem_rdata = 0, busy = 0, done = 0, addr_err = 0.
  - Latched address and data registers = 0.
  - RAM contents are not reset.
- State machine has three states: IDLE, ACCESS, DONE.
- IDLE:
  - At an edge with wr_req or rd_req high: latch mem_addr, mem_wdata and the op (write has priority when both are high; the read is dropped, not queued).
  - Load counter = WAIT_CYCLES and go to ACCESS.
  - Requests are sampled only in IDLE; levels held during busy are ignored.
- ACCESS:
  - busy = 1. Each edge, if counter != 1 then decrement.
  - If counter == 1, perform the access at that edge and go to DONE:
    - In-range write: RAM[latched addr] <= latched data. mem_rdata is unchanged.
    - In-range read: mem_rdata <= RAM[latched addr].
    - Out of range (any latched address bit at or above DEPTH_LOG2 is set): no RAM write, mem_rdata <= 0 for reads and unchanged for writes, error flag set.
- DONE:
  - busy = 1, done = 1, addr_err = error flag.
  - Next edge: go to IDLE and clear done, addr_err and the error flag.
- Timing:
  - Request accepted at edge E0 → done high during the cycle after edge E0+WAIT_CYCLES.
  - Earliest next acceptance is edge E0+WAIT_CYCLES+2.
- Input stability: mem_addr and mem_wdata may change after acceptance; only latched copies are used.
- mem_rdata holds its value between reads, because the MDDR samples it continuously.
- Reset mid-access aborts immediately: no RAM write occurs if the access edge has not been reached, and outputs return to reset values.
- WAIT_CYCLES outside 1..15 is a configuration error (elaboration check).

Test Plan:
- Basic write/read, WAIT_CYCLES=2:
  - Write 16'hA5C3 to addr 16'h0010 → busy high 3 cycles, done pulses in the 3rd.
  - Then read addr 16'h0010 → mem_rdata = 16'hA5C3 on the done cycle and held afterwards.
- Simultaneous requests:
  - rd_req = wr_req = 1, addr 16'h0004, wdata 16'h1234 → write performed, mem_rdata unchanged.
  - Subsequent read returns 16'h1234.
- Out of range:
  - Write 16'hFFFF to addr 16'h0100 with DEPTH_LOG2=8 → done and addr_err together, RAM[0x00] unchanged.
  - Read addr 16'h0100 → addr_err = 1, mem_rdata = 0.
- Busy ignore:
  - Hold rd_req high throughout a write and change mem_addr/mem_wdata mid-access → the write uses the values latched at acceptance.
  - The read is accepted only at the first IDLE edge after DONE.
- Reset mid-access:
  - Assert reset one cycle after accepting a write of 16'h0BAD to addr 5 → busy and done fall asynchronously.
  - Subsequent read of addr 5 returns its prior contents, not 16'h0BAD.
- Latency sweep:
  - WAIT_CYCLES = 1 and 15 → done appears exactly WAIT_CYCLES+1 cycles after the accepting edge.
  - Back-to-back requests complete every WAIT_CYCLES+2 cycles.
